// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the zero-register index for the register file
package regfile_pkg;
    localparam int WIDTH_D = 64;
    localparam int DEPTH_D = 32;
    localparam int NREAD_D = 2;
    localparam int XZR     = 31;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port and per-port read request/response bus of the register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int DEPTH = DEPTH_D,
    parameter int NREAD = NREAD_D
);
    localparam int AW = $clog2(DEPTH);
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_valid;
    modport master(output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data, rd_valid);
    modport slave(input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port (mux tree, zero/bypass priority, output register)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_D,
    parameter int DEPTH    = DEPTH_D,
    parameter int ZERO_REG = DEPTH_D - 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DEPTH*WIDTH-1:0] i_mem,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_en,
    input  logic [AW-1:0]          i_addr,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid
);
    // Heap-ordered mux tree: leaves at DEPTH+i, node n steers on the address bit of its level
    logic [WIDTH-1:0] w_node [1:2*DEPTH-1];
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
        assign w_node[DEPTH+i] = i_mem[i*WIDTH +: WIDTH];
    end

    for (genvar n = 1; n < DEPTH; n++) begin : g_node
        localparam int B = AW - $clog2(n + 1);
        assign w_node[n] = i_addr[B] ? w_node[2*n+1] : w_node[2*n];
    end

    always_comb begin
        w_sel = (int'(i_addr) == ZERO_REG) ? '0 :
                (i_wr_en && i_wr_addr == i_addr) ? i_wr_data : w_node[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) r_data <= w_sel;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file, one write port, NREAD registered read ports
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_D,
    parameter int DEPTH    = DEPTH_D,
    parameter int NREAD    = NREAD_D,
    parameter int ZERO_REG = DEPTH - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "regfile_mp: DEPTH must be a power of 2 and at least 2");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $fatal(1, "regfile_mp: NREAD must be 1..4");
    end

    logic [DEPTH*WIDTH-1:0] r_mem;
    logic [NREAD*WIDTH-1:0] w_rd_data;
    logic [NREAD-1:0]       w_rd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_mem <= '0;
        else if (bus.wr_en && int'(bus.wr_addr) != ZERO_REG) r_mem[bus.wr_addr*WIDTH +: WIDTH] <= bus.wr_data;
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        regfile_rd_port #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)
        ) u_rd (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_mem    (r_mem),
            .i_wr_en  (bus.wr_en),
            .i_wr_addr(bus.wr_addr),
            .i_wr_data(bus.wr_data),
            .i_en     (bus.rd_en[p]),
            .i_addr   (bus.rd_addr[p*AW +: AW]),
            .o_data   (w_rd_data[p*WIDTH +: WIDTH]),
            .o_valid  (w_rd_valid[p])
        );
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = w_rd_valid;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp against an array-based reference model
module tb_regfile_mp;
    import regfile_pkg::*;
    localparam int W = 64, D = 32, N = 2, AW = 5;
    typedef struct packed {logic v; logic [W-1:0] d;} exp_t;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NREAD(N)) bus ();
    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(N), .ZERO_REG(XZR)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0, errors = 0;
    exp_t q0[$], q1[$];
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_hold [N];
    bit in_reset = 1'b1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a, input logic we,
                                              input logic [AW-1:0] wa, input logic [W-1:0] wd);
        if (int'(a) == XZR) return '0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        for (int p = 0; p < N; p++) m_hold[p] = '0;
    endtask

    // One stimulus cycle: drive at negedge, predict what the next rising edge registers
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [N-1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic [AW-1:0] ra [N];
        exp_t e [N];
        @(negedge clk);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_en = re; bus.rd_addr = {ra1, ra0};
        ra[0] = ra0; ra[1] = ra1;
        for (int p = 0; p < N; p++) begin
            if (!in_reset && re[p]) m_hold[p] = ref_read(ra[p], we, wa, wd);
            e[p] = '{v: !in_reset && re[p], d: m_hold[p]};
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
        if (!in_reset && we && int'(wa) != XZR) m_mem[wa] = wd;
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        in_reset = 1'b1;
        q0.delete();
        q1.delete();
        clear_model();
        #1;
        check("reset_async_valid", 256'(bus.rd_valid), 256'(0));
        check("reset_async_data", 256'(bus.rd_data), 256'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = '0;
        reset_n = 1'b1;
        in_reset = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("port0", 256'({bus.rd_valid[0], bus.rd_data[0 +: W]}), 256'(e));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("port1", 256'({bus.rd_valid[1], bus.rd_data[W +: W]}), 256'(e));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic we;
        logic [AW-1:0] wa, ra0, ra1;
        logic [W-1:0] wd;
        logic [N-1:0] re;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = '0; bus.rd_addr = '0;
        clear_model();
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < D; i++) cyc(1'b1, AW'(i), {$urandom, $urandom}, 2'b00, '0, '0);
        cyc(1'b0, '0, '0, 2'b11, 5'd5, 5'd6);
        assert_reset();
        repeat (3) cyc(1'b1, 5'd4, 64'hABCD, 2'b11, 5'd4, 5'd9);
        release_reset();
        for (int i = 0; i < D; i++) cyc(1'b0, '0, '0, 2'b11, AW'(i), AW'(D - 1 - i));

        cyc(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 2'b00, '0, '0);
        cyc(1'b0, '0, '0, 2'b01, 5'd5, '0);
        cyc(1'b1, 5'd7, 64'hFFFF, 2'b00, '0, '0);
        cyc(1'b1, 5'd7, 64'h1234, 2'b10, '0, 5'd7);
        cyc(1'b1, 5'd31, '1, 2'b11, 5'd31, 5'd31);
        cyc(1'b0, '0, '0, 2'b11, 5'd31, 5'd31);
        for (int i = 0; i < D; i++) cyc(1'b1, AW'(i), W'(i * 'h1111), 2'b00, '0, '0);
        cyc(1'b0, '0, '0, 2'b11, 5'd3, 5'd3);
        cyc(1'b0, '0, '0, 2'b11, 5'd0, 5'd30);
        cyc(1'b0, '0, '0, 2'b11, 5'd3, 5'd3);
        cyc(1'b0, '0, '0, 2'b10, 5'd12, 5'd30);

        repeat (400) begin
            we  = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, D - 1));
            wd  = {$urandom, $urandom};
            re  = N'($urandom_range(0, 3));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : AW'($urandom_range(0, D - 1));
            cyc(we, wa, wd, re, ra0, ra1);
        end

        cyc(1'b0, '0, '0, 2'b00, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drain", 256'(q0.size() + q1.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
